// File: rtl/shift_seq_pkg.sv
// Shared constants and enums for the shift command sequencer.
package shift_seq_pkg;
  localparam int WIDTH = 16;
  localparam int AMT_W = 5;
  localparam int SH_W  = 4;

  typedef enum logic [1:0] {
    OP_LSR = 2'b00,
    OP_ASR = 2'b01,
    OP_LSL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;
endpackage

// File: rtl/shift_seq_if.sv
// Command and result handshakes of shift_seq; master = producer/consumer side, slave = sequencer.
interface shift_seq_if;
  import shift_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport slave (
    input  in_valid, in_op, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_op, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/shift_seq_bit_reverse16.sv
// Combinational 16-bit bit reversal; only built when SHIFT_SEQ_LSL_EN is defined.
`ifdef SHIFT_SEQ_LSL_EN
module bit_reverse16 (
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);
  for (genvar g = 0; g < 16; g++) begin : g_rev
    assign o_q[g] = i_d[15-g];
  end
endmodule
`endif

// File: rtl/shift_seq.sv
// Shift command sequencer driving a registered 16-bit right shifter.
// Define SHIFT_SEQ_LSL_EN to implement op 10 (LSL) via bit reversal; otherwise it is an error op.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_if.slave       bus,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_fill,
  output logic [SH_W-1:0]  sh_control,
  input  logic [WIDTH-1:0] sh_result,
  output logic [CNT_W-1:0] op_count
);
  state_e           r_state;
  state_e           w_next;
  op_e              w_op;
  logic             w_accept;
  logic             w_legal;
  logic             w_bypass;
  logic             w_sign;
  logic [WIDTH-1:0] w_issue_a;
  logic [WIDTH-1:0] w_issue_fill;
  logic [WIDTH-1:0] w_bypass_data;
  logic [WIDTH-1:0] w_cap_data;

  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_fill;
  logic [SH_W-1:0]  r_sh_ctl;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic [CNT_W-1:0] r_count;

  assign w_op     = op_e'(bus.in_op);
  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_bypass = bus.in_amt[AMT_W-1];
  assign w_sign   = bus.in_data[WIDTH-1];

  assign w_issue_fill  = (w_op == OP_ASR) ? {WIDTH{w_sign}} : {WIDTH{1'b0}};
  assign w_bypass_data = (w_op == OP_ASR) ? {WIDTH{w_sign}} : {WIDTH{1'b0}};

`ifdef SHIFT_SEQ_LSL_EN
  logic             r_is_lsl;
  logic [WIDTH-1:0] w_rev_in;
  logic [WIDTH-1:0] w_rev_out;

  bit_reverse16 u_rev_operand (.i_d(bus.in_data), .o_q(w_rev_in));
  bit_reverse16 u_rev_result  (.i_d(sh_result),   .o_q(w_rev_out));

  assign w_legal    = (w_op != OP_RSV);
  assign w_issue_a  = (w_op == OP_LSL) ? w_rev_in : bus.in_data;
  assign w_cap_data = r_is_lsl ? w_rev_out : sh_result;

  // Remember whether the in-flight command needs its result un-reversed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_lsl <= 1'b0;
    end else if (w_accept) begin
      r_is_lsl <= (w_op == OP_LSL);
    end else begin
      r_is_lsl <= r_is_lsl;
    end
  end
`else
  assign w_legal    = (w_op == OP_LSR) || (w_op == OP_ASR);
  assign w_issue_a  = bus.in_data;
  assign w_cap_data = sh_result;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; amounts of 16+ and illegal ops skip the shifter entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_legal && !w_bypass) begin
            w_next = ST_ISSUE;
          end else begin
            w_next = ST_DONE;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shifter drive, result capture and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_a     <= '0;
      r_sh_fill  <= '0;
      r_sh_ctl   <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_next == ST_ISSUE) begin
        r_sh_a    <= w_issue_a;
        r_sh_fill <= w_issue_fill;
        r_sh_ctl  <= bus.in_amt[SH_W-1:0];
      end else begin
        r_sh_a    <= '0;
        r_sh_fill <= '0;
        r_sh_ctl  <= '0;
      end

      if (w_accept && (w_next == ST_DONE)) begin
        r_out_data <= w_legal ? w_bypass_data : {WIDTH{1'b0}};
        r_out_err  <= ~w_legal;
      end else if (r_state == ST_CAPTURE) begin
        r_out_data <= w_cap_data;
        r_out_err  <= 1'b0;
      end else begin
        r_out_data <= r_out_data;
        r_out_err  <= r_out_err;
      end

      if ((r_state == ST_DONE) && bus.out_ready) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;
  assign sh_a          = r_sh_a;
  assign sh_fill       = r_sh_fill;
  assign sh_control    = r_sh_ctl;
  assign op_count      = r_count;
endmodule
